qracc_sram_ctrl: RTL and testbench

- Digital-side controller for the QrAcc SRAM array. Terminates the sram_itf slave modport and sequences the analog SRAM controls (PCH, WL, WRITE, WR_DATA, CSEL, SAEN) carried in to_analog_t.
- Captures SA_OUT from from_analog_t and returns read data.
- Sits between the weight-loading master (host/DMA) and the analog macro.

---
 rtl/qracc_sram_ctrl.sv | 164 ++++++++++++++++
 tb/tb_qracc_sram_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qracc_sram_ctrl.sv
// QrAcc SRAM array controller: accepts single-row read/write requests from the
// weight-loading master and sequences the analog macro controls through
// precharge, wordline, sense and response phases. All outputs are registered.
module qracc_sram_ctrl #(
    parameter int numRows   = 128,
    parameter int numCols   = 32,
    parameter int pchCycles = 1,
    parameter int wlCycles  = 2,
    parameter int saCycles  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cim_busy_i,
    input  logic                       rq_wr_i,
    input  logic                       rq_valid_i,
    output logic                       rq_ready_o,
    input  logic [$clog2(numRows)-1:0] addr_i,
    input  logic [numCols-1:0]         wr_data_i,
    output logic                       rd_valid_o,
    output logic [numCols-1:0]         rd_data_o,
    output logic [numRows-1:0]         wl_o,
    output logic                       pch_o,
    output logic                       write_o,
    output logic [numCols-1:0]         wr_data_o,
    output logic [numCols-1:0]         csel_o,
    output logic                       saen_o,
    input  logic [numCols-1:0]         sa_out_i,
    output logic                       busy_o
);

    localparam int AW = $clog2(numRows);
    localparam int CW = 16;

    localparam logic [CW-1:0] PCH_LAST = CW'(pchCycles - 1);
    localparam logic [CW-1:0] WL_LAST  = CW'(wlCycles - 1);
    localparam logic [CW-1:0] SA_LAST  = CW'(saCycles - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PCH,
        ST_WL,
        ST_SENSE,
        ST_RESP
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [AW-1:0]       r_addr;
    logic                r_wr;
    logic [numCols-1:0]  r_wr_data;

    logic [numRows-1:0]  w_wl_dec;
    logic                w_addr_ok;

    // One-hot row decode of the latched address; rows beyond numRows decode to zero
    always_comb begin
        w_wl_dec = '0;
        for (int unsigned i = 0; i < numRows; i++) begin
            if (r_addr == AW'(i)) begin
                w_wl_dec[i] = 1'b1;
            end
        end
    end

    assign w_addr_ok = |w_wl_dec;

    // Access sequencer: state, phase counter and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wr       <= 1'b0;
            r_wr_data  <= '0;
            rq_ready_o <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            wl_o       <= '0;
            pch_o      <= 1'b0;
            write_o    <= 1'b0;
            wr_data_o  <= '0;
            csel_o     <= '0;
            saen_o     <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rq_valid_i && rq_ready_o) begin
                        r_addr     <= addr_i;
                        r_wr       <= rq_wr_i;
                        r_wr_data  <= wr_data_i;
                        r_cnt      <= '0;
                        rq_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                        pch_o      <= 1'b1;
                        r_state    <= ST_PCH;
                    end else begin
                        rq_ready_o <= !cim_busy_i;
                    end
                end

                ST_PCH: begin
                    if (r_cnt == PCH_LAST) begin
                        r_cnt     <= '0;
                        pch_o     <= 1'b0;
                        wl_o      <= w_wl_dec;
                        csel_o    <= '1;
                        write_o   <= r_wr;
                        wr_data_o <= r_wr ? r_wr_data : '0;
                        r_state   <= ST_WL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_WL: begin
                    if (r_cnt == WL_LAST) begin
                        r_cnt     <= '0;
                        csel_o    <= '0;
                        write_o   <= 1'b0;
                        wr_data_o <= '0;
                        if (r_wr) begin
                            wl_o       <= '0;
                            busy_o     <= 1'b0;
                            rq_ready_o <= !cim_busy_i;
                            r_state    <= ST_IDLE;
                        end else begin
                            // wordline stays on through sensing
                            saen_o  <= 1'b1;
                            r_state <= ST_SENSE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_SENSE: begin
                    if (r_cnt == SA_LAST) begin
                        r_cnt      <= '0;
                        saen_o     <= 1'b0;
                        wl_o       <= '0;
                        rd_valid_o <= 1'b1;
                        rd_data_o  <= w_addr_ok ? sa_out_i : '0;
                        r_state    <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    rd_valid_o <= 1'b0;
                    busy_o     <= 1'b0;
                    rq_ready_o <= !cim_busy_i;
                    r_state    <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qracc_sram_ctrl.sv
// Self-checking bench for qracc_sram_ctrl: two instances (default timing and a
// stretched-phase, non-power-of-two row count), each driving a behavioural SRAM
// array model; expectations come from phase arithmetic and a word-level memory.
module tb_qracc_sram_ctrl;

    localparam int NC = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          cim_busy = 1'b0;
    logic          rq_wr = 1'b0;
    logic          rq_valid = 1'b0;
    logic          sel = 1'b0;
    logic [6:0]    addr = '0;
    logic [NC-1:0] wdata = '0;

    // default instance signals
    logic          d_ready, d_rv, d_pch, d_write, d_saen, d_busy;
    logic [NC-1:0] d_rdata, d_wrd, d_csel, d_sa;
    logic [127:0]  d_wl;
    // stretched instance signals
    logic          t_ready, t_rv, t_pch, t_write, t_saen, t_busy;
    logic [NC-1:0] t_rdata, t_wrd, t_csel, t_sa;
    logic [99:0]   t_wl;

    qracc_sram_ctrl #(.numRows(128), .numCols(NC), .pchCycles(1), .wlCycles(2), .saCycles(1)) u_d (
        .clk(clk), .rst(rst), .cim_busy_i(cim_busy), .rq_wr_i(rq_wr),
        .rq_valid_i(rq_valid && !sel), .rq_ready_o(d_ready), .addr_i(addr),
        .wr_data_i(wdata), .rd_valid_o(d_rv), .rd_data_o(d_rdata), .wl_o(d_wl),
        .pch_o(d_pch), .write_o(d_write), .wr_data_o(d_wrd), .csel_o(d_csel),
        .saen_o(d_saen), .sa_out_i(d_sa), .busy_o(d_busy));

    qracc_sram_ctrl #(.numRows(100), .numCols(NC), .pchCycles(3), .wlCycles(4), .saCycles(2)) u_t (
        .clk(clk), .rst(rst), .cim_busy_i(cim_busy), .rq_wr_i(rq_wr),
        .rq_valid_i(rq_valid && sel), .rq_ready_o(t_ready), .addr_i(addr),
        .wr_data_i(wdata), .rd_valid_o(t_rv), .rd_data_o(t_rdata), .wl_o(t_wl),
        .pch_o(t_pch), .write_o(t_write), .wr_data_o(t_wrd), .csel_o(t_csel),
        .saen_o(t_saen), .sa_out_i(t_sa), .busy_o(t_busy));

    // Analog array models: write drivers store into selected rows, sense amps
    // return the selected row; idle/unselected reads return junk patterns.
    logic [NC-1:0] amem_d [128];
    logic [NC-1:0] amem_t [100];

    always @(posedge clk) begin
        if (d_write) for (int i = 0; i < 128; i++) if (d_wl[i]) amem_d[i] <= d_wrd;
        if (t_write) for (int j = 0; j < 100; j++) if (t_wl[j]) amem_t[j] <= t_wrd;
    end

    always_comb begin
        d_sa = 32'hA5A5_A5A5;
        if (d_saen) begin
            d_sa = '1;
            for (int i = 0; i < 128; i++) if (d_wl[i]) d_sa = amem_d[i];
        end
    end

    always_comb begin
        t_sa = 32'h5A5A_5A5A;
        if (t_saen) begin
            t_sa = '1;
            for (int j = 0; j < 100; j++) if (t_wl[j]) t_sa = amem_t[j];
        end
    end

    // observation of the selected instance
    logic [5:0]    obs_ctl;   // {pch, write, saen, rd_valid, ready, busy}
    logic [127:0]  obs_wl;
    logic [NC-1:0] obs_wrd, obs_csel, obs_rdata;
    always_comb begin
        if (sel) begin
            obs_ctl   = {t_pch, t_write, t_saen, t_rv, t_ready, t_busy};
            obs_wl    = {28'b0, t_wl};
            obs_wrd   = t_wrd;
            obs_csel  = t_csel;
            obs_rdata = t_rdata;
        end else begin
            obs_ctl   = {d_pch, d_write, d_saen, d_rv, d_ready, d_busy};
            obs_wl    = d_wl;
            obs_wrd   = d_wrd;
            obs_csel  = d_csel;
            obs_rdata = d_rdata;
        end
    end

    // reference state
    int            n_pass = 0;
    int            n_total = 0;
    int            P = 1, W = 2, S = 1, ROWS = 128;
    logic [NC-1:0] mem_d [128];
    logic [NC-1:0] mem_t [128];
    bit            written_d [128];
    logic [NC-1:0] last_rd_d = '0;
    logic [NC-1:0] last_rd_t = '0;

    task automatic set_sel(input logic s);
        sel = s;
        if (s) begin P = 3; W = 4; S = 2; ROWS = 100; end
        else   begin P = 1; W = 2; S = 1; ROWS = 128; end
    endtask

    // One access: wait for ready, present the request, then check every
    // cycle up to and including the cycle ready returns.
    task automatic access(input logic wr, input int a, input logic [NC-1:0] data, input logic hold);
        int            waitc, rdy;
        logic          e_pch, e_wlon, e_wlph, e_sa, e_rv;
        logic [5:0]    e_ctl;
        logic [127:0]  e_wl;
        logic [NC-1:0] e_rd, e_wrd, e_csel, e_last;
        waitc = 0;
        while (obs_ctl[1] !== 1'b1 && waitc < 60) begin
            @(negedge clk);
            waitc++;
        end
        n_total++;
        if (obs_ctl[1] !== 1'b1) begin
            $display("FAIL ready_timeout addr=%0d got ready=%b exp 1", a, obs_ctl[1]);
            rq_valid = 1'b0;
            return;
        end
        n_pass++;
        rq_wr = wr; addr = a[6:0]; wdata = data; rq_valid = 1'b1;
        e_rd = '0;
        if (wr) begin
            if (a < ROWS) begin
                if (sel) mem_t[a] = data; else begin mem_d[a] = data; written_d[a] = 1'b1; end
            end
        end else begin
            if (a < ROWS) e_rd = sel ? mem_t[a] : mem_d[a];
            if (sel) last_rd_t = e_rd; else last_rd_d = e_rd;
        end
        rdy = wr ? P + W + 1 : P + W + S + 2;
        @(posedge clk);
        for (int n = 1; n <= rdy; n++) begin
            @(negedge clk);
            if (n == 1 && !hold) rq_valid = 1'b0;
            e_pch  = (n <= P);
            e_wlph = (n > P) && (n <= P + W);
            e_wlon = (n > P) && (n <= P + W + (wr ? 0 : S));
            e_sa   = !wr && (n > P + W) && (n <= P + W + S);
            e_rv   = !wr && (n == P + W + S + 1);
            e_ctl  = {e_pch, wr && e_wlph, e_sa, e_rv, n == rdy, n < rdy};
            e_wl   = '0;
            if (e_wlon && a < ROWS) e_wl[a] = 1'b1;
            e_wrd  = (wr && e_wlph) ? data : '0;
            e_csel = e_wlph ? '1 : '0;
            n_total++;
            if (obs_ctl !== e_ctl) $display("FAIL ctl a=%0d wr=%b n=%0d got %b exp %b", a, wr, n, obs_ctl, e_ctl);
            else n_pass++;
            n_total++;
            if (obs_wl !== e_wl) $display("FAIL wl a=%0d n=%0d got %h exp %h", a, n, obs_wl, e_wl);
            else n_pass++;
            n_total++;
            if ({obs_wrd, obs_csel} !== {e_wrd, e_csel})
                $display("FAIL wrdata_csel a=%0d n=%0d got %h/%h exp %h/%h", a, n, obs_wrd, obs_csel, e_wrd, e_csel);
            else n_pass++;
            n_total++;
            if (obs_ctl[5] && (obs_ctl[3] || obs_ctl[4] || |obs_wl))
                $display("FAIL phase_excl n=%0d got ctl=%b wl_any=%b exp no overlap", n, obs_ctl, |obs_wl);
            else n_pass++;
            if (e_rv || n == rdy) begin
                e_last = sel ? last_rd_t : last_rd_d;
                n_total++;
                if (obs_rdata !== e_last) $display("FAIL rd_data a=%0d n=%0d got %h exp %h", a, n, obs_rdata, e_last);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({obs_ctl, obs_wl, obs_wrd, obs_csel, obs_rdata} !== '0)
            $display("FAIL reset_outputs got ctl=%b wl=%h rd=%h exp all 0", obs_ctl, obs_wl, obs_rdata);
        else n_pass++;
        rst = 1'b0;
        last_rd_d = '0; last_rd_t = '0;
        @(negedge clk);
        n_total++;
        if (obs_ctl !== 6'b000010) $display("FAIL reset_release_ready got %b exp %b", obs_ctl, 6'b000010);
        else n_pass++;
    endtask

    task automatic test_write_read;
        set_sel(1'b0);
        access(1'b1, 5, 32'hDEAD_BEEF, 1'b0);
        access(1'b0, 5, '0, 1'b0);
        access(1'b1, 127, 32'h1234_5678, 1'b0);
        access(1'b0, 127, '0, 1'b0);
    endtask

    task automatic test_random;
        int a;
        set_sel(1'b0);
        for (int k = 0; k < 20; k++) begin
            a = $urandom_range(127, 0);
            if (written_d[a] && $urandom_range(1, 0) == 1) access(1'b0, a, '0, 1'b0);
            else access(1'b1, a, $urandom, 1'b0);
        end
    endtask

    task automatic test_phase_timing;
        set_sel(1'b1);
        access(1'b1, 7, 32'hCAFE_F00D, 1'b0);
        access(1'b0, 7, '0, 1'b0);
        access(1'b1, 99, 32'h0BAD_CAFE, 1'b0);
        access(1'b0, 99, '0, 1'b0);
    endtask

    task automatic test_addr_oob;
        set_sel(1'b1);
        access(1'b1, 110, 32'hFFFF_0000, 1'b0);
        access(1'b0, 110, '0, 1'b0);
        set_sel(1'b0);
    endtask

    task automatic test_backpressure;
        logic [NC-1:0] dv;
        set_sel(1'b0);
        dv = $urandom;
        @(negedge clk);
        cim_busy = 1'b1;
        @(negedge clk);
        rq_wr = 1'b1; addr = 7'd9; wdata = dv; rq_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_total++;
            if (obs_ctl !== 6'b0 || obs_wl !== '0)
                $display("FAIL backpressure c=%0d got ctl=%b wl=%h exp 0", c, obs_ctl, obs_wl);
            else n_pass++;
        end
        cim_busy = 1'b0;
        access(1'b1, 9, dv, 1'b0);
        access(1'b0, 9, '0, 1'b0);
    endtask

    task automatic test_back_to_back;
        set_sel(1'b0);
        for (int i = 0; i < 4; i++) access(1'b1, i, $urandom, 1'b1);
        for (int i = 0; i < 4; i++) access(1'b0, i, '0, (i < 3));
    endtask

    task automatic test_reset_mid_read;
        set_sel(1'b0);
        access(1'b0, 5, '0, 1'b0);
        rq_wr = 1'b0; addr = 7'd5; rq_valid = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= P + W + 1; n++) begin
            @(negedge clk);
            if (n == 1) rq_valid = 1'b0;
        end
        n_total++;
        if (obs_ctl[3] !== 1'b1) $display("FAIL mid_read_in_sense got saen=%b exp 1", obs_ctl[3]);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({obs_ctl, obs_wl, obs_wrd, obs_csel} !== '0)
            $display("FAIL mid_read_abort got ctl=%b wl=%h exp all 0", obs_ctl, obs_wl);
        else n_pass++;
        rst = 1'b0;
        last_rd_d = '0; last_rd_t = '0;
        @(negedge clk);
        n_total++;
        if (obs_ctl !== 6'b000010 || obs_rdata !== '0)
            $display("FAIL mid_read_release got ctl=%b rd=%h exp 000010/0", obs_ctl, obs_rdata);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_total++;
            if (obs_ctl[2] !== 1'b0) $display("FAIL mid_read_no_rv c=%0d got %b exp 0", c, obs_ctl[2]);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            written_d[i] = 1'b0;
            mem_d[i] = '0;
            mem_t[i] = '0;
        end
        test_reset;
        test_write_read;
        test_phase_timing;
        test_addr_oob;
        test_backpressure;
        test_back_to_back;
        test_random;
        test_reset_mid_read;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
